// File: rtl/enc_output_framer_pkg.sv
// Shared types and constants for the encoder output framer and its skid FIFO.
package enc_output_framer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TAIL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DATA_BEATS_1056    = 132;
   localparam int DATA_BEATS_6144    = 768;
   localparam int TAIL_BEATS_DEFAULT = 2;
   localparam int FIFO_ENTRY_W       = 27;
   localparam int BEAT_CNT_W         = 10;

   typedef struct packed {
      logic [23:0] data;
      logic        sof;
      logic        eof;
      logic        tail;
   } fifo_entry_t;

   function automatic logic [BEAT_CNT_W-1:0] data_beats(input logic bs);
      return bs ? BEAT_CNT_W'(DATA_BEATS_6144) : BEAT_CNT_W'(DATA_BEATS_1056);
   endfunction

endpackage

// File: rtl/enc_skid_fifo.sv
// Output skid FIFO: combinational read of the head entry, push accepted on full
// when a pop happens in the same cycle, synchronous flush.
module enc_skid_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_pop;
   logic             do_push;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/enc_output_framer.sv
// Frames encoder beats (data then tail) into flagged 24-bit words through a skid FIFO.
module enc_output_framer
   import enc_output_framer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TAIL_BEATS = TAIL_BEATS_DEFAULT
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        blocksize,
   input  logic        in_valid,
   input  logic [7:0]  xk_in,
   input  logic [7:0]  zk_in,
   input  logic [7:0]  zk_prime_in,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [23:0] out_data,
   output logic        out_sof,
   output logic        out_eof,
   output logic        out_tail,
   output logic        busy,
   output logic        frame_done,
   output logic        overflow,
   output logic        extra_beat
);

   state_t                 state_q, state_d;
   logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d;
   logic                   bs_q, bs_d;
   logic                   overflow_q, overflow_d;
   logic                   extra_q, extra_d;
   logic                   frame_done_q, frame_done_d;

   logic                   in_frame;
   logic                   beat_in_frame;
   logic                   last_data;
   logic                   last_tail;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   fifo_entry_t            wr_entry;
   fifo_entry_t            rd_entry;
   logic [FIFO_ENTRY_W-1:0] rd_bits;

   assign in_frame      = (state_q == ST_DATA) || (state_q == ST_TAIL);
   assign beat_in_frame = in_valid & ~start & in_frame;
   assign last_data     = (cnt_q == data_beats(bs_q) - BEAT_CNT_W'(1));
   assign last_tail     = (cnt_q == BEAT_CNT_W'(TAIL_BEATS - 1));
   assign fifo_pop      = out_ready & ~fifo_empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_DATA;
      end else begin
         case (state_q)
            ST_DATA: if (in_valid && last_data) state_d = ST_TAIL;
            ST_TAIL: if (in_valid && last_tail) state_d = ST_DONE;
            ST_DONE: if (fifo_empty)            state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      busy      = in_frame;
      out_valid = ~fifo_empty;
      rd_entry  = rd_bits;
      out_data  = rd_entry.data;
      out_sof   = rd_entry.sof;
      out_eof   = rd_entry.eof;
      out_tail  = rd_entry.tail;
   end

   // The counter advances on every in-frame beat, dropped or not, so framing never slips.
   always_comb begin
      cnt_d        = cnt_q;
      bs_d         = bs_q;
      overflow_d   = overflow_q;
      extra_d      = extra_q;
      frame_done_d = 1'b0;
      if (start) begin
         cnt_d      = '0;
         bs_d       = blocksize;
         overflow_d = 1'b0;
         extra_d    = 1'b0;
      end else begin
         if (beat_in_frame) begin
            if (((state_q == ST_DATA) && last_data) || ((state_q == ST_TAIL) && last_tail))
               cnt_d = '0;
            else
               cnt_d = cnt_q + BEAT_CNT_W'(1);
            if (fifo_full && !out_ready) overflow_d = 1'b1;
         end
         if (in_valid && !in_frame) extra_d = 1'b1;
         frame_done_d = beat_in_frame && (state_q == ST_TAIL) && last_tail;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         bs_q         <= 1'b0;
         overflow_q   <= 1'b0;
         extra_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         bs_q         <= bs_d;
         overflow_q   <= overflow_d;
         extra_q      <= extra_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      wr_entry.data = {xk_in, zk_in, zk_prime_in};
      wr_entry.sof  = (state_q == ST_DATA) && (cnt_q == '0);
      wr_entry.eof  = (state_q == ST_TAIL) && last_tail;
      wr_entry.tail = (state_q == ST_TAIL);
   end

   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign extra_beat = extra_q;

   enc_skid_fifo #(
      .WIDTH (FIFO_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (start),
      .push    (beat_in_frame),
      .wr_data (wr_entry),
      .pop     (fifo_pop),
      .rd_data (rd_bits),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_enc_output_framer.sv
// Directed bench for enc_output_framer: vector table plus multi-cycle framing scenarios.
module tb_enc_output_framer;

   localparam int DEPTH = 8;
   localparam int TB    = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        blocksize = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  xk_in = '0;
   logic [7:0]  zk_in = '0;
   logic [7:0]  zk_prime_in = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [23:0] out_data;
   logic        out_sof, out_eof, out_tail;
   logic        busy, frame_done, overflow, extra_beat;

   always #5 clock = ~clock;

   enc_output_framer #(.FIFO_DEPTH(DEPTH), .TAIL_BEATS(TB)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .blocksize   (blocksize),
      .in_valid    (in_valid),
      .xk_in       (xk_in),
      .zk_in       (zk_in),
      .zk_prime_in (zk_prime_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sof     (out_sof),
      .out_eof     (out_eof),
      .out_tail    (out_tail),
      .busy        (busy),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .extra_beat  (extra_beat)
   );

   typedef struct packed {
      logic [23:0] data;
      logic        sof;
      logic        eof;
      logic        tail;
   } word_t;

   typedef struct {
      logic        st, bs, iv, rdy;
      logic [23:0] d;
      logic        e_valid;
      logic [23:0] e_data;
      logic        e_sof;
      logic        e_busy;
      logic        e_extra;
   } vec_t;

   int    n_checks = 0;
   int    n_errors = 0;
   word_t exp_q[$];
   word_t mon_w;
   int    m_occ = 0;
   bit    m_frame = 0;
   int    m_idx = 0;
   int    m_n = 132;
   bit    m_ovf = 0;
   bit    m_extra = 0;
   int    m_acc = 0;
   int    n_pops = 0;
   int    fd_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [23:0] pat(input int s, input int i);
      return {8'(i), 8'(s * 16 + i / 256), 8'(i * 3 + s)};
   endfunction

   // Popped words are compared against the bench's expected-word queue.
   always @(negedge clock) begin
      if (reset_n && out_valid === 1'b1 && out_ready) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word actual=%0h required=none", out_data);
         end else begin
            mon_w = exp_q.pop_front();
            chk("word_data", 32'(out_data), 32'(mon_w.data));
            chk("word_flags", 32'({out_sof, out_eof, out_tail}),
                32'({mon_w.sof, mon_w.eof, mon_w.tail}));
         end
      end
      if (reset_n && frame_done === 1'b1) fd_count++;
   end

   // Drives one cycle of inputs and advances the framing/occupancy model.
   task automatic cycle(input logic st, input logic bs, input logic iv, input logic rdy,
                        input logic [23:0] d);
      bit    pop;
      bit    acc;
      word_t w;
      start = st; blocksize = bs; in_valid = iv; out_ready = rdy;
      {xk_in, zk_in, zk_prime_in} = d;
      pop = (m_occ > 0) && rdy;
      acc = 0;
      if (st) begin
         m_frame = 1; m_idx = 0; m_n = bs ? 768 : 132; m_ovf = 0; m_extra = 0;
      end else if (iv) begin
         if (m_frame) begin
            if (m_occ < DEPTH || pop) begin
               acc    = 1;
               w.data = d;
               w.sof  = (m_idx == 0);
               w.eof  = (m_idx == m_n + TB - 1);
               w.tail = (m_idx >= m_n);
               exp_q.push_back(w);
               m_acc++;
            end else begin
               m_ovf = 1;
            end
            if (m_idx == m_n + TB - 1) m_frame = 0;
            m_idx++;
         end else begin
            m_extra = 1;
         end
      end
      m_occ = m_occ - int'(pop) + int'(acc);
      @(posedge clock);
      #1;
      if (st) begin
         exp_q.delete();
         m_occ = 0;
      end
   endtask

   task automatic check_flags(input string name);
      chk({name, "_overflow"}, 32'(overflow), 32'(m_ovf));
      chk({name, "_extra_beat"}, 32'(extra_beat), 32'(m_extra));
   endtask

   task automatic check_zero(input string name);
      chk({name, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({name, "_out_data"}, 32'(out_data), 32'h0);
      chk({name, "_sof_eof_tail"}, 32'({out_sof, out_eof, out_tail}), 32'h0);
      chk({name, "_busy"}, 32'(busy), 32'h0);
      chk({name, "_frame_done"}, 32'(frame_done), 32'h0);
      chk({name, "_overflow"}, 32'(overflow), 32'h0);
      chk({name, "_extra_beat"}, 32'(extra_beat), 32'h0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_occ = 0; m_frame = 0; m_idx = 0; m_ovf = 0; m_extra = 0;
   endtask

   vec_t vt[6];
   int   p0;

   initial begin
      vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 24'h112233, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 24'hAABBCC, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 24'h010203, 1'b1, 24'h010203, 1'b1, 1'b1, 1'b0};
      vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h040506, 1'b1, 24'h010203, 1'b1, 1'b1, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b1, 24'h040506, 1'b0, 1'b1, 1'b0};
      vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0};

      #12;
      check_zero("por");
      @(posedge clock);
      #1 reset_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         cycle(vt[v].st, vt[v].bs, vt[v].iv, vt[v].rdy, vt[v].d);
         chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vt[v].e_valid));
         chk($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vt[v].e_data));
         chk($sformatf("vec%0d_out_sof", v), 32'(out_sof), 32'(vt[v].e_sof));
         chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].e_busy));
         chk($sformatf("vec%0d_extra_beat", v), 32'(extra_beat), 32'(vt[v].e_extra));
         chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'h0);
      end

      // 1056-bit frame, always ready.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      fd_count = 0; p0 = n_pops;
      for (int i = 0; i < 134; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, pat(1, i));
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      chk("f1056_words", 32'(n_pops - p0), 32'd134);
      chk("f1056_frame_done", 32'(fd_count), 32'd1);
      chk("f1056_pending", 32'(exp_q.size()), 32'd0);
      chk("f1056_busy", 32'(busy), 32'h0);
      check_flags("f1056");
      $display("frame 1056: words=%0d frame_done=%0d", n_pops - p0, fd_count);

      // 6144-bit frame with out_ready toggling; overfill drops beats but framing holds.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 24'h0);
      fd_count = 0; p0 = n_pops; m_acc = 0;
      for (int i = 0; i < 770; i++)
         cycle(1'b0, 1'b1, 1'b1, (i < 760) ? 1'(i % 2) : 1'b1, pat(2, i));
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
      chk("f6144_words", 32'(n_pops - p0), 32'(m_acc));
      chk("f6144_frame_done", 32'(fd_count), 32'd1);
      chk("f6144_pending", 32'(exp_q.size()), 32'd0);
      chk("f6144_overflow_set", 32'(overflow), 32'h1);
      check_flags("f6144");
      $display("frame 6144: words=%0d accepted=%0d overflow=%0b", n_pops - p0, m_acc, overflow);

      // Stall: 9 beats into an 8-entry FIFO with out_ready low.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      p0 = n_pops;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, pat(3, i));
         chk($sformatf("stall%0d_data", i), 32'(out_data), 32'(pat(3, 0)));
         chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'h1);
      end
      chk("stall_overflow", 32'(overflow), 32'h1);
      check_flags("stall");
      repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      chk("stall_words", 32'(n_pops - p0), 32'd8);
      $display("stall: words=%0d overflow=%0b", n_pops - p0, overflow);

      // Restart at beat 50 with words still buffered.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b1, 1'(i < 45), pat(4, i));
      cycle(1'b1, 1'b0, 1'b1, 1'b0, pat(4, 50));
      chk("restart_flushed", 32'(out_valid), 32'h0);
      chk("restart_busy", 32'(busy), 32'h1);
      check_flags("restart");
      fd_count = 0; p0 = n_pops;
      for (int i = 0; i < 134; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, pat(5, i));
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      chk("restart_words", 32'(n_pops - p0), 32'd134);
      chk("restart_frame_done", 32'(fd_count), 32'd1);
      chk("restart_pending", 32'(exp_q.size()), 32'd0);
      $display("restart: words=%0d frame_done=%0d", n_pops - p0, fd_count);

      // Asynchronous reset while in TAIL with a full FIFO and overflow set.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      for (int i = 0; i < 133; i++) cycle(1'b0, 1'b0, 1'b1, 1'(i < 120), pat(6, i));
      chk("tailrst_busy", 32'(busy), 32'h1);
      chk("tailrst_overflow", 32'(overflow), 32'h1);
      in_valid = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      check_zero("tailrst");
      model_reset();
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, pat(7, i));
      chk("postrst_out_valid", 32'(out_valid), 32'h0);
      chk("postrst_busy", 32'(busy), 32'h0);
      chk("postrst_extra_set", 32'(extra_beat), 32'h1);
      check_flags("postrst");
      $display("reset in tail: out_valid=%0b extra_beat=%0b", out_valid, extra_beat);

      // Beat after eof while the FIFO still holds the frame's last words.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
      chk("done_extra_cleared", 32'(extra_beat), 32'h0);
      fd_count = 0;
      for (int i = 0; i < 134; i++) cycle(1'b0, 1'b0, 1'b1, 1'(i < 132), pat(8, i));
      cycle(1'b0, 1'b0, 1'b1, 1'b0, pat(9, 0));
      chk("done_extra_set", 32'(extra_beat), 32'h1);
      chk("done_held_valid", 32'(out_valid), 32'h1);
      chk("done_busy", 32'(busy), 32'h0);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
      chk("done_drained", 32'(out_valid), 32'h0);
      chk("done_pending", 32'(exp_q.size()), 32'd0);
      chk("done_frame_done", 32'(fd_count), 32'd1);
      check_flags("done");
      $display("extra beat in done: extra_beat=%0b out_valid=%0b", extra_beat, out_valid);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
